// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage state encoding, reset/NOP constants and PC alignment helper
package riscv_pkg;
  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, DROP} fetch_state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, hold and flush-to-NOP
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);
  // load a fetched word, or flush to an invalid NOP; otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (load) begin
      if_id_pc    <= pc;
      if_id_instr <= instr;
      if_id_valid <= 1'b1;
    end else if (flush) begin
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: single-outstanding instruction fetch FSM with skid buffer and IF/ID register
module if_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  input  logic        redirect,
  input  logic        stall,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_current,
  output logic [31:0] add_pc_out,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        fetch_misaligned
);
  fetch_state_t state;
  logic [31:0] skid;
  logic [31:0] pc_aligned;
  logic redir, take, flush, drop_next, mis_next;
  assign pc_aligned = align_pc(pc_next);
  assign mis_next   = |pc_next[1:0];
  assign imem_addr  = pc_current;
  assign add_pc_out = pc_current + 32'd4;
  assign redir      = redirect && state != BOOT;
  assign take       = !redir && !stall && ((state == WAIT && imem_rvalid) || state == HOLD);
  assign flush      = redir || (!stall && !take);
  assign drop_next  = (state == WAIT && !imem_rvalid) || state == DROP;
  // fetch FSM: PC, skid buffer, request pulse and misalignment pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= BOOT;
      pc_current       <= RESET_PC;
      skid             <= '0;
      imem_req         <= 1'b0;
      fetch_misaligned <= 1'b0;
    end else begin
      imem_req         <= 1'b0;
      fetch_misaligned <= 1'b0;
      if (redir) begin
        pc_current       <= pc_aligned;
        fetch_misaligned <= mis_next;
        skid             <= '0;
        state            <= drop_next ? DROP : REQ;
        imem_req         <= !drop_next;
      end else if (take) begin
        pc_current       <= pc_aligned;
        fetch_misaligned <= mis_next;
        state            <= REQ;
        imem_req         <= 1'b1;
      end else begin
        case (state)
          BOOT: begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
          REQ: state <= WAIT;
          WAIT: if (imem_rvalid) begin
            skid  <= imem_rdata;
            state <= HOLD;
          end
          DROP: if (imem_rvalid) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .load        (take),
    .flush       (flush),
    .pc          (pc_current),
    .instr       (state == HOLD ? skid : imem_rdata),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid)
  );
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed vector table plus randomized run against a behavioural fetch model
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] Z   = 32'h0;
  localparam logic [31:0] D1  = 32'h0010_0093;
  localparam logic [31:0] D2  = 32'h0020_0113;
  localparam logic [31:0] D3  = 32'h0030_0193;
  localparam logic [31:0] DX  = 32'hDEAD_BEEF;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk, rst, redirect, stall, imem_rvalid;
  logic [31:0] pc_next, imem_rdata;
  logic imem_req, if_id_valid, fetch_misaligned;
  logic [31:0] imem_addr, pc_current, add_pc_out, if_id_pc, if_id_instr;

  int n_chk = 0;
  int n_fail = 0;
  int cnt = 0;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .pc_next(pc_next), .redirect(redirect), .stall(stall),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .imem_req(imem_req),
    .imem_addr(imem_addr), .pc_current(pc_current), .add_pc_out(add_pc_out),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .fetch_misaligned(fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst, redir, stall, rv;
    logic [31:0] rdata, pcn;
    logic req;
    logic [31:0] addr;
    logic vld;
    logic [31:0] ipc, ins;
    logic mis;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic rd, input logic st, input logic rv,
                     input logic [31:0] rdata, input logic [31:0] pcn, input logic req,
                     input logic [31:0] addr, input logic vld, input logic [31:0] ipc,
                     input logic [31:0] ins, input logic mis);
    vec_t v;
    v.rst = r; v.redir = rd; v.stall = st; v.rv = rv; v.rdata = rdata; v.pcn = pcn;
    v.req = req; v.addr = addr; v.vld = vld; v.ipc = ipc; v.ins = ins; v.mis = mis;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // behavioural model: fetch tracked as "requesting / awaiting data / data parked / discarding"
  logic m_boot, m_req, m_pend, m_skid_v, m_drop, m_vld, m_mis;
  logic [31:0] m_pc, m_skid, m_ipc, m_ins;

  task automatic m_step();
    logic wr;
    logic [31:0] wd;
    wr = 1'b0;
    wd = Z;
    if (rst) begin
      m_boot = 1; m_req = 0; m_pend = 0; m_skid_v = 0; m_drop = 0; m_skid = Z;
      m_pc = Z; m_ipc = Z; m_ins = NOP; m_vld = 0; m_mis = 0;
    end else begin
      m_mis = 0;
      if (m_boot) begin
        m_boot = 0; m_req = 1;
      end else if (redirect) begin
        m_pc = {pc_next[31:2], 2'b00};
        m_mis = |pc_next[1:0];
        m_skid_v = 0; m_skid = Z;
        if ((m_pend && !imem_rvalid) || m_drop) begin m_drop = 1; m_req = 0; end
        else begin m_drop = 0; m_req = 1; end
        m_pend = 0;
      end else if (m_req) begin
        m_req = 0; m_pend = 1;
      end else if (m_pend && imem_rvalid) begin
        m_pend = 0;
        if (stall) begin m_skid_v = 1; m_skid = imem_rdata; end
        else begin wr = 1; wd = imem_rdata; end
      end else if (m_skid_v && !stall) begin
        m_skid_v = 0; wr = 1; wd = m_skid;
      end else if (m_drop && imem_rvalid) begin
        m_drop = 0; m_req = 1;
      end
      if (wr) begin
        m_ipc = m_pc; m_ins = wd; m_vld = 1;
        m_pc = {pc_next[31:2], 2'b00};
        m_mis = |pc_next[1:0];
        m_req = 1;
      end else if ((redirect && !m_boot) || !stall) begin
        m_ins = NOP; m_vld = 0;
      end
    end
  endtask

  initial begin
    rst = 1; redirect = 0; stall = 0; imem_rvalid = 0; pc_next = Z; imem_rdata = Z;
    add(H,L,L,L,Z ,Z            , L,Z            ,L,Z     ,NOP,L);
    add(L,L,L,L,Z ,Z            , H,Z            ,L,Z     ,NOP,L);
    add(L,L,L,L,Z ,32'h4        , L,Z            ,L,Z     ,NOP,L);
    add(L,L,L,H,D1,32'h4        , H,32'h4        ,H,Z     ,D1 ,L);
    add(L,L,L,L,Z ,32'h8        , L,32'h4        ,L,Z     ,NOP,L);
    add(L,L,L,H,D2,32'h8        , H,32'h8        ,H,32'h4 ,D2 ,L);
    add(L,L,H,L,Z ,32'hC        , L,32'h8        ,H,32'h4 ,D2 ,L);
    add(L,L,H,H,D3,32'hC        , L,32'h8        ,H,32'h4 ,D2 ,L);
    add(L,L,H,L,Z ,32'hC        , L,32'h8        ,H,32'h4 ,D2 ,L);
    add(L,L,H,L,Z ,32'hC        , L,32'h8        ,H,32'h4 ,D2 ,L);
    add(L,L,L,L,Z ,32'hC        , H,32'hC        ,H,32'h8 ,D3 ,L);
    add(L,L,L,L,Z ,32'h10       , L,32'hC        ,L,32'h8 ,NOP,L);
    add(L,H,L,L,Z ,32'h40       , L,32'h40       ,L,32'h8 ,NOP,L);
    add(L,L,L,H,DX,32'h44       , H,32'h40       ,L,32'h8 ,NOP,L);
    add(L,L,L,L,Z ,32'h44       , L,32'h40       ,L,32'h8 ,NOP,L);
    add(L,L,H,H,D1,32'h44       , L,32'h40       ,L,32'h8 ,NOP,L);
    add(L,H,H,L,Z ,32'h80       , H,32'h80       ,L,32'h8 ,NOP,L);
    add(L,L,L,L,Z ,32'h84       , L,32'h80       ,L,32'h8 ,NOP,L);
    add(L,L,L,H,D2,32'h84       , H,32'h84       ,H,32'h80,D2 ,L);
    add(L,H,L,L,Z ,32'h102      , H,32'h100      ,L,32'h80,NOP,H);
    add(L,L,L,L,Z ,32'h104      , L,32'h100      ,L,32'h80,NOP,L);
    add(L,H,L,H,D1,32'hFFFF_FFFC, H,32'hFFFF_FFFC,L,32'h80,NOP,L);
    add(L,L,L,L,Z ,Z            , L,32'hFFFF_FFFC,L,32'h80,NOP,L);
    add(H,L,L,L,Z ,Z            , L,Z            ,L,Z     ,NOP,L);
    add(L,L,L,H,D1,Z            , H,Z            ,L,Z     ,NOP,L);
    add(L,L,L,H,D1,32'h4        , L,Z            ,L,Z     ,NOP,L);
    add(L,L,L,H,D3,32'h4        , H,32'h4        ,H,Z     ,D3 ,L);
    foreach (tbl[i]) begin
      rst = tbl[i].rst; redirect = tbl[i].redir; stall = tbl[i].stall;
      imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata; pc_next = tbl[i].pcn;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
      chk($sformatf("v%0d imem_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("v%0d pc_current", i), pc_current, tbl[i].addr);
      chk($sformatf("v%0d add_pc_out", i), add_pc_out, tbl[i].addr + 32'd4);
      chk($sformatf("v%0d if_id_valid", i), {31'b0, if_id_valid}, {31'b0, tbl[i].vld});
      chk($sformatf("v%0d if_id_pc", i), if_id_pc, tbl[i].ipc);
      chk($sformatf("v%0d if_id_instr", i), if_id_instr, tbl[i].ins);
      chk($sformatf("v%0d fetch_misaligned", i), {31'b0, fetch_misaligned}, {31'b0, tbl[i].mis});
    end
    rst = 1; redirect = 0; stall = 0; imem_rvalid = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      m_step();
      #1;
      chk($sformatf("r%0d imem_req", c), {31'b0, imem_req}, {31'b0, m_req});
      chk($sformatf("r%0d imem_addr", c), imem_addr, m_pc);
      chk($sformatf("r%0d add_pc_out", c), add_pc_out, m_pc + 32'd4);
      chk($sformatf("r%0d if_id_valid", c), {31'b0, if_id_valid}, {31'b0, m_vld});
      chk($sformatf("r%0d if_id_pc", c), if_id_pc, m_ipc);
      chk($sformatf("r%0d if_id_instr", c), if_id_instr, m_ins);
      chk($sformatf("r%0d fetch_misaligned", c), {31'b0, fetch_misaligned}, {31'b0, m_mis});
      if (m_req) cnt = int'($urandom_range(3, 1)) + 1;
      rst = ($urandom_range(299) == 0);
      redirect = ($urandom_range(9) == 0);
      stall = ($urandom_range(2) == 0);
      pc_next = $urandom;
      if ($urandom_range(3) != 0) pc_next[1:0] = 2'b00;
      if ($urandom_range(31) == 0) pc_next = 32'hFFFF_FFFC;
      imem_rvalid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        imem_rvalid = (cnt == 0);
      end else if ($urandom_range(15) == 0) imem_rvalid = 1'b1;
      imem_rdata = $urandom;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
